// File: rtl/control_pkg.sv
// Shared types and constants for the accumulator-core sequencer.
// Holds the opcode map, the FSM state encoding and the decoded strobe bundle.
// Imported by opcode_decode and control_fsm.
package control_pkg;

  localparam int OPCODE_W = 5;

  // Opcodes 0..ALU_MAX are plain ALU operations.
  localparam logic [OPCODE_W-1:0] ALU_MAX   = 5'd16;
  localparam logic [OPCODE_W-1:0] OP_LOADM  = 5'd17;
  localparam logic [OPCODE_W-1:0] OP_LOADV  = 5'd18;
  localparam logic [OPCODE_W-1:0] OP_STOREM = 5'd19;
  localparam logic [OPCODE_W-1:0] OP_STOREV = 5'd20;
  localparam logic [OPCODE_W-1:0] OP_SLT    = 5'd21;
  localparam logic [OPCODE_W-1:0] OP_BEQ    = 5'd22;
  localparam logic [OPCODE_W-1:0] OP_RB     = 5'd23;
  localparam logic [OPCODE_W-1:0] OP_AB     = 5'd24;
  localparam logic [OPCODE_W-1:0] OP_DONE   = 5'd31;
  // 25..30 are reserved and decode as illegal.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } state_t;

  // Strobes implied by an opcode; the FSM decides in which state they appear.
  typedef struct packed {
    logic acc_we;   // accumulator write in EXEC
    logic reg_we;   // register write in EXEC
    logic cmp_en;   // BEQ compare
    logic rel_en;   // relative jump
    logic abs_en;   // absolute jump
    logic mem_rd;   // data-memory read (LOADM)
    logic mem_wr;   // data-memory write (STOREM)
    logic illegal;  // reserved opcode
    logic halt;     // DONE
  } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Purpose: combinational opcode -> ctrl_t strobe bundle.
// Ports: opcode (in, OPCODE_W bits), ctrl (out, ctrl_t).
// Pure decode; no state, zero latency.
module opcode_decode
  import control_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    if (opcode <= ALU_MAX) begin
      ctrl.acc_we = 1'b1;
    end else begin
      case (opcode)
        OP_LOADM:        ctrl.mem_rd  = 1'b1;
        OP_LOADV,
        OP_SLT:          ctrl.acc_we  = 1'b1;
        OP_STOREM:       ctrl.mem_wr  = 1'b1;
        OP_STOREV:       ctrl.reg_we  = 1'b1;
        OP_BEQ: begin
                         ctrl.cmp_en  = 1'b1;
                         ctrl.rel_en  = 1'b1;
        end
        OP_RB:           ctrl.rel_en  = 1'b1;
        OP_AB:           ctrl.abs_en  = 1'b1;
        OP_DONE:         ctrl.halt    = 1'b1;
        default:         ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Purpose: multi-cycle sequencer; fetches one instruction per handshake, pulses datapath strobes.
// Ports: clk/reset_n, start, instr_valid/instruction/instr_ready, mem_ready, datapath strobes,
//        alu_op, illegal_op, sticky mem_error/done, saturating cycle_count.
module control_fsm
  import control_pkg::*;
#(
  parameter int INSTR_W     = 9,
  parameter int OP_W        = 5,
  parameter int OP_LSB      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instr_ready,
  input  logic               mem_ready,
  output logic               dat_read_enable,
  output logic               dat_write_enable,
  output logic               reg_write_enable,
  output logic               acc_write_enable,
  output logic               acc_src,
  output logic               compare_enable,
  output logic               reljump_enable,
  output logic               absjump_enable,
  output logic               pc_advance,
  output logic [OP_W-1:0]    alu_op,
  output logic               illegal_op,
  output logic               mem_error,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count
);

  // Wait counter indexes MEM_WAIT cycles 0..MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [INSTR_W-1:0]  ir;
  logic [WAIT_W-1:0]   wait_cnt;
  ctrl_t               dec;
  logic                restart;
  logic                timeout_hit;
  logic                counting;
  logic                ir_unused;

  // Operand bits of ir feed the datapath elsewhere; only the opcode is decoded here.
  assign ir_unused = ^ir;

  assign alu_op = ir[OP_LSB +: OP_W];

  opcode_decode u_dec (
    .opcode (ir[OP_LSB +: OP_W]),
    .ctrl   (dec)
  );

  assign restart     = (state == IDLE || state == HALT) && start;
  // mem_ready in the last allowed cycle still commits.
  assign timeout_hit = (state == MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LAST);
  assign counting    = (state == FETCH) || (state == EXEC) || (state == MEM_WAIT);

  always_comb begin
    state_nxt        = state;
    instr_ready      = 1'b0;
    dat_read_enable  = 1'b0;
    dat_write_enable = 1'b0;
    reg_write_enable = 1'b0;
    acc_write_enable = 1'b0;
    // Mux select idles at ALU; IDLE keeps it at 0 so the reset state is all-zero.
    acc_src          = (state != IDLE);
    compare_enable   = 1'b0;
    reljump_enable   = 1'b0;
    absjump_enable   = 1'b0;
    pc_advance       = 1'b0;
    illegal_op       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        acc_write_enable = dec.acc_we;
        reg_write_enable = dec.reg_we;
        compare_enable   = dec.cmp_en;
        reljump_enable   = dec.rel_en;
        absjump_enable   = dec.abs_en;
        illegal_op       = dec.illegal;
        // Memory ops retire in MEM_WAIT; DONE never retires.
        pc_advance       = !(dec.mem_rd || dec.mem_wr || dec.halt);
        if (dec.mem_rd || dec.mem_wr) state_nxt = MEM_WAIT;
        else if (dec.halt)            state_nxt = HALT;
        else                          state_nxt = FETCH;
      end
      MEM_WAIT: begin
        dat_read_enable  = dec.mem_rd;
        dat_write_enable = dec.mem_wr;
        if (mem_ready) begin
          pc_advance       = 1'b1;
          acc_write_enable = dec.mem_rd;
          acc_src          = !dec.mem_rd;
          state_nxt        = FETCH;
        end else if (timeout_hit) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ir          <= '0;
      wait_cnt    <= '0;
      mem_error   <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && instr_valid) ir <= instruction;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      if (restart) begin
        mem_error   <= 1'b0;
        done        <= 1'b0;
        cycle_count <= '0;
      end else begin
        if (timeout_hit)                mem_error <= 1'b1;
        if (state == EXEC && dec.halt)  done      <= 1'b1;
        if (counting && !(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: table of per-cycle vectors plus hand sequences for
// memory timeout, timeout-cycle commit and asynchronous reset in MEM_WAIT.
module tb_control_fsm;

  typedef struct packed {
    logic       rdy, rd, wr, rwe, awe, asrc, cmp, rel, abs, pca;
    logic [4:0] alu;
    logic       ill, merr, dn;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    logic       st, iv;
    logic [8:0] ins;
    logic       mr;
    out_t       e;
  } vec_t;

  // Strobe patterns: {rdy rd wr rwe awe asrc cmp rel abs pca}
  localparam logic [9:0] F_IDLE  = 10'b0000000000;
  localparam logic [9:0] F_FETCH = 10'b1000010000;
  localparam logic [9:0] F_ALU   = 10'b0000110001;
  localparam logic [9:0] F_QUIET = 10'b0000010000;
  localparam logic [9:0] F_RD    = 10'b0100010000;
  localparam logic [9:0] F_RDC   = 10'b0100100001;
  localparam logic [9:0] F_WR    = 10'b0010010000;
  localparam logic [9:0] F_BEQ   = 10'b0000011101;
  localparam logic [9:0] F_AB    = 10'b0000010011;
  localparam logic [9:0] F_NOP   = 10'b0000010001;
  localparam logic [9:0] F_REGW  = 10'b0001010001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, instr_valid, mem_ready;
  logic [8:0] instruction;
  logic       instr_ready, dat_read_enable, dat_write_enable, reg_write_enable;
  logic       acc_write_enable, acc_src, compare_enable, reljump_enable, absjump_enable;
  logic       pc_advance, illegal_op, mem_error, done;
  logic [4:0] alu_op;
  logic [15:0] cycle_count;

  int n_vec = 0;
  int n_bad = 0;

  out_t  exp_q[$];
  string tag_q[$];
  vec_t  tbl[21];
  out_t  got;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr_valid(instr_valid),
    .instruction(instruction), .instr_ready(instr_ready), .mem_ready(mem_ready),
    .dat_read_enable(dat_read_enable), .dat_write_enable(dat_write_enable),
    .reg_write_enable(reg_write_enable), .acc_write_enable(acc_write_enable),
    .acc_src(acc_src), .compare_enable(compare_enable), .reljump_enable(reljump_enable),
    .absjump_enable(absjump_enable), .pc_advance(pc_advance), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_error(mem_error), .done(done), .cycle_count(cycle_count)
  );

  assign got = {instr_ready, dat_read_enable, dat_write_enable, reg_write_enable,
                acc_write_enable, acc_src, compare_enable, reljump_enable,
                absjump_enable, pc_advance, alu_op, illegal_op, mem_error, done, cycle_count};

  function automatic out_t o(input logic [9:0] f, input int alu, input logic [2:0] flg, input int cnt);
    out_t r;
    {r.rdy, r.rd, r.wr, r.rwe, r.awe, r.asrc, r.cmp, r.rel, r.abs, r.pca} = f;
    r.alu = 5'(alu);
    {r.ill, r.merr, r.dn} = flg;
    r.cnt = 16'(cnt);
    return r;
  endfunction

  function automatic vec_t v(input int st, input int iv, input int ins, input int mr, input out_t e);
    vec_t r;
    r.st  = st[0];
    r.iv  = iv[0];
    r.ins = 9'(ins);
    r.mr  = mr[0];
    r.e   = e;
    return r;
  endfunction

  task automatic check(input string name, input out_t g, input out_t e);
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %p required %p", name, g, e);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; expectation is compared at the falling edge.
  task automatic step(input string name, input vec_t x);
    @(posedge clk);
    #1;
    start       = x.st;
    instr_valid = x.iv;
    instruction = x.ins;
    mem_ready   = x.mr;
    exp_q.push_back(x.e);
    tag_q.push_back(name);
  endtask

  always @(negedge clk) begin
    out_t  e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, got, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line program: ALU, LOADM with 3-cycle wait, BEQ, AB, reserved, STOREV, DONE.
    tbl[0]  = v(1, 0, 'h000, 0, o(F_IDLE,   0, 3'b000,  0));
    tbl[1]  = v(0, 1, 'h035, 0, o(F_FETCH,  0, 3'b000,  0));
    tbl[2]  = v(0, 0, 'h000, 0, o(F_ALU,    3, 3'b000,  1));
    tbl[3]  = v(0, 1, 'h110, 0, o(F_FETCH,  3, 3'b000,  2));
    tbl[4]  = v(0, 0, 'h000, 0, o(F_QUIET, 17, 3'b000,  3));
    tbl[5]  = v(0, 0, 'h000, 0, o(F_RD,    17, 3'b000,  4));
    tbl[6]  = v(0, 0, 'h000, 0, o(F_RD,    17, 3'b000,  5));
    tbl[7]  = v(0, 0, 'h000, 1, o(F_RDC,   17, 3'b000,  6));
    tbl[8]  = v(0, 1, 'h160, 0, o(F_FETCH, 17, 3'b000,  7));
    tbl[9]  = v(0, 0, 'h000, 0, o(F_BEQ,   22, 3'b000,  8));
    tbl[10] = v(0, 1, 'h180, 0, o(F_FETCH, 22, 3'b000,  9));
    tbl[11] = v(0, 0, 'h000, 0, o(F_AB,    24, 3'b000, 10));
    tbl[12] = v(0, 1, 'h1A0, 0, o(F_FETCH, 24, 3'b000, 11));
    tbl[13] = v(0, 0, 'h000, 0, o(F_NOP,   26, 3'b100, 12));
    tbl[14] = v(1, 0, 'h035, 1, o(F_FETCH, 26, 3'b000, 13));
    tbl[15] = v(0, 1, 'h140, 0, o(F_FETCH, 26, 3'b000, 14));
    tbl[16] = v(0, 1, 'h1F0, 0, o(F_REGW,  20, 3'b000, 15));
    tbl[17] = v(0, 1, 'h1F0, 0, o(F_FETCH, 20, 3'b000, 16));
    tbl[18] = v(0, 0, 'h000, 0, o(F_QUIET, 31, 3'b000, 17));
    tbl[19] = v(0, 1, 'h035, 1, o(F_QUIET, 31, 3'b001, 18));
    tbl[20] = v(0, 0, 'h000, 0, o(F_QUIET, 31, 3'b001, 18));

    reset_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instruction = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", got, o(F_IDLE, 0, 3'b000, 0));
    #2 reset_n = 1'b1;

    for (int i = 0; i < 21; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // STOREM with no mem_ready: 15 wait cycles then HALT with mem_error.
    step("halt_restart", v(1, 0, 'h000, 0, o(F_QUIET, 31, 3'b001, 18)));
    step("to_fetch",     v(0, 1, 'h130, 0, o(F_FETCH, 31, 3'b000,  0)));
    step("storem_exec",  v(0, 0, 'h000, 0, o(F_QUIET, 19, 3'b000,  1)));
    for (int i = 0; i < 15; i++)
      step($sformatf("storem_wait%0d", i), v(0, 0, 'h000, 0, o(F_WR, 19, 3'b000, 2 + i)));
    step("timeout_halt", v(0, 1, 'h035, 1, o(F_QUIET, 19, 3'b010, 17)));
    step("halt_ignore",  v(1, 0, 'h000, 0, o(F_QUIET, 19, 3'b010, 17)));
    step("err_cleared",  v(0, 1, 'h110, 0, o(F_FETCH, 19, 3'b000,  0)));

    // LOADM where mem_ready arrives in the final allowed wait cycle.
    step("loadm_exec",   v(0, 0, 'h000, 0, o(F_QUIET, 17, 3'b000,  1)));
    for (int i = 0; i < 14; i++)
      step($sformatf("loadm_wait%0d", i), v(0, 0, 'h000, 0, o(F_RD, 17, 3'b000, 2 + i)));
    step("late_commit",  v(0, 0, 'h000, 1, o(F_RDC,   17, 3'b000, 16)));
    step("post_commit",  v(0, 1, 'h130, 0, o(F_FETCH, 17, 3'b000, 17)));
    step("storem2_exec", v(0, 0, 'h000, 0, o(F_QUIET, 19, 3'b000, 18)));
    step("storem2_wait", v(0, 0, 'h000, 0, o(F_WR,    19, 3'b000, 19)));

    // Asynchronous reset in the middle of MEM_WAIT drops the write request immediately.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", got, o(F_IDLE, 0, 3'b000, 0));
    #1 reset_n = 1'b1;
    step("rst_idle",  v(1, 0, 'h000, 0, o(F_IDLE,  0, 3'b000, 0)));
    step("rst_fetch", v(0, 0, 'h000, 0, o(F_FETCH, 0, 3'b000, 0)));

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
